hour_counter_cfg: RTL and testbench
===================================

HOUR_COUNTER_CFG -- requirements
Module: hour_counter_cfg

Interface
REQ-001 The block SHALL accept parameter TENS_W, default 2, giving the width of the hour tens digit output.
REQ-002 The block SHALL accept parameter UNITS_W, default 4, giving the width of the hour units digit output (BCD, minimum 4).
REQ-003 The block SHALL accept parameter HOUR_MAX, default 23, giving the last canonical hour before wrap; legal range 11..23.
REQ-004 The block SHALL use one clock and an asynchronous, active-high reset, named as the codebase does.
REQ-005 Port clk  input  1  rising-edge clock.
REQ-006 Port rst  input  1  asynchronous active-high reset.
REQ-007 Port inc  input  1  hour-advance enable (tens-of-minutes carry), sampled on the clk rising edge.
REQ-008 Port timemod  input  1  display mode: 0 = 24-hour, 1 = 12-hour.
REQ-009 Port hr_tens  output  TENS_W  displayed hour tens digit, BCD.
REQ-010 Port hr_units  output  UNITS_W  displayed hour units digit, BCD.
REQ-011 Port pm  output  1  high when the canonical hour is 12 or greater.
REQ-012 Port day_carry  output  1  one-cycle pulse on wrap from HOUR_MAX to 0.
REQ-013 Port heptazero  output  1  high when timemod=0 and the displayed hour is 00.
REQ-014 Port trizero  output  1  high when timemod=1 and the displayed hour is 12 with pm=0.

Function
REQ-015 The block SHALL hold one canonical hour register H, range 0..HOUR_MAX, independent of timemod.
REQ-016 On a clk edge with inc=1 and H<HOUR_MAX, H SHALL become H+1.
REQ-017 On a clk edge with inc=1 and H=HOUR_MAX, H SHALL become 0 and day_carry SHALL be 1 for exactly the following cycle.
REQ-018 With inc=0, H SHALL hold and day_carry SHALL be 0.
REQ-019 In 24-hour mode, hr_tens:hr_units SHALL equal the BCD encoding of H.
REQ-020 In 12-hour mode, the display SHALL be the BCD encoding of (H mod 12), except that a value of 0 SHALL display as 12.
REQ-021 The display, pm, heptazero and trizero SHALL be combinational functions of H and timemod, with zero cycles of latency from H.
REQ-022 A change of timemod SHALL leave H unchanged and SHALL re-encode the display in the same cycle.
REQ-023 Unused upper bits of hr_tens and hr_units SHALL be driven 0.

Reset
REQ-024 Asserting rst SHALL immediately force H=0 and day_carry=0, regardless of clk.
REQ-025 While rst=1, the outputs SHALL read 00 with heptazero=1 in 24-hour mode, and 12 with pm=0 and trizero=1 in 12-hour mode.
REQ-026 An inc pulse coincident with rst deassertion SHALL NOT be required to take effect; the first guaranteed advance is on the next edge.

Configuration
REQ-027 Macro HOUR_LOAD_EN SHALL, when defined, add input ports: load (1), load_tens (TENS_W), load_units (UNITS_W), and output port load_err (1).
REQ-028 With HOUR_LOAD_EN defined, load=1 with a valid canonical value (units<=9 and value<=HOUR_MAX) SHALL set H to that value on the clk edge; this load is always 24-hour encoded, whatever timemod is.
REQ-029 With HOUR_LOAD_EN defined, a load of an invalid value SHALL leave H unchanged and SHALL pulse load_err for one cycle.
REQ-030 With HOUR_LOAD_EN defined, load SHALL take priority over inc on the same edge; that inc SHALL be discarded and day_carry SHALL NOT pulse.
REQ-031 Without HOUR_LOAD_EN, the load ports and load_err SHALL be absent, and H SHALL change only through inc and rst.

Verification
REQ-032 Reset with timemod=0 -> display 00, heptazero=1, pm=0, day_carry=0; switch timemod=1 -> display 12, trizero=1.
REQ-033 Reset, then 23 inc pulses with timemod=0 -> display 23; 24th pulse -> display 00, day_carry high exactly one cycle.
REQ-034 Set H=13 via 13 incs, toggle timemod 0->1->0 -> display 01 with pm=1, then 13; H unchanged throughout.
REQ-035 HOUR_MAX=11 build, 12 incs -> wrap to 0 with day_carry pulse; pm never asserts.
REQ-036 HOUR_LOAD_EN: load 2:0 with inc=1 -> display 20, no increment; load 2:5 -> load_err one cycle, H unchanged.
REQ-037 Assert rst asynchronously mid-cycle at H=17 -> outputs reach the reset values before the next clk edge.

Source files
------------

// File: rtl/hour_counter_cfg.sv
// ----------------------------------------------------------------------------
// hour_counter_cfg
//
// Hour stage of a digital clock. One canonical hour register (0..HOUR_MAX)
// advances on each inc strobe and wraps to 0 with a one-cycle day_carry
// pulse. The BCD display, AM/PM flag and zero-hour flags are decoded
// combinationally from the hour register and the display mode, so a mode
// change re-encodes the display in the same cycle without touching the
// stored hour.
//
// Build option:
//   HOUR_LOAD_EN  when defined, adds a direct 24-hour-encoded hour load
//                 port with validity checking and a load_err pulse.
//
// Parameters:
//   TENS_W    width of hr_tens (default 2)
//   UNITS_W   width of hr_units, BCD, >= 4 (default 4)
//   HOUR_MAX  last hour before wrap, 11..23 (default 23)
//
// Ports:
//   clk        in   rising-edge clock
//   rst        in   asynchronous active-high reset
//   inc        in   hour advance strobe (tens-of-minutes carry)
//   timemod    in   0 = 24-hour display, 1 = 12-hour display
//   hr_tens    out  displayed hour tens digit (BCD)
//   hr_units   out  displayed hour units digit (BCD)
//   pm         out  canonical hour >= 12
//   day_carry  out  one-cycle pulse on wrap HOUR_MAX -> 0
//   heptazero  out  24-hour mode showing 00
//   trizero    out  12-hour mode showing 12 AM
//   load       in   (HOUR_LOAD_EN) load strobe, beats inc
//   load_tens  in   (HOUR_LOAD_EN) load value tens digit
//   load_units in   (HOUR_LOAD_EN) load value units digit
//   load_err   out  (HOUR_LOAD_EN) one-cycle pulse on an invalid load
// ----------------------------------------------------------------------------
module hour_counter_cfg #(
    parameter int TENS_W   = 2,
    parameter int UNITS_W  = 4,
    parameter int HOUR_MAX = 23
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               inc,
    input  logic               timemod,
`ifdef HOUR_LOAD_EN
    input  logic               load,
    input  logic [TENS_W-1:0]  load_tens,
    input  logic [UNITS_W-1:0] load_units,
    output logic               load_err,
`endif
    output logic [TENS_W-1:0]  hr_tens,
    output logic [UNITS_W-1:0] hr_units,
    output logic               pm,
    output logic               day_carry,
    output logic               heptazero,
    output logic               trizero
);

    localparam logic [4:0] HMAX = 5'(HOUR_MAX);

    // Splits a 0..23 value into {tens, units} BCD nibbles.
    function automatic logic [7:0] to_bcd(input logic [4:0] v);
        logic [4:0] t;
        logic [4:0] u;
        t = v / 5'd10;
        u = v - (t * 5'd10);
        return {t[3:0], u[3:0]};
    endfunction

    logic [4:0] hour;
    logic [4:0] hour_nxt;
    logic       carry_nxt;

`ifdef HOUR_LOAD_EN
    logic [31:0] load_val;
    logic        load_ok;
    logic        err_nxt;

    // Load value is always 24-hour encoded, independent of timemod.
    always_comb begin
        load_val = (32'(load_tens) * 32'd10) + 32'(load_units);
        load_ok  = (32'(load_units) <= 32'd9) && (load_val <= 32'(HOUR_MAX));
    end
`endif

    always_comb begin
        hour_nxt  = hour;
        carry_nxt = 1'b0;
`ifdef HOUR_LOAD_EN
        err_nxt   = 1'b0;
        // A load on the same edge swallows inc, so no wrap can occur.
        if (load) begin
            if (load_ok) begin
                hour_nxt = load_val[4:0];
            end else begin
                err_nxt = 1'b1;
            end
        end else
`endif
        if (inc) begin
            if (hour >= HMAX) begin
                hour_nxt  = 5'd0;
                carry_nxt = 1'b1;
            end else begin
                hour_nxt = hour + 5'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hour      <= 5'd0;
            day_carry <= 1'b0;
`ifdef HOUR_LOAD_EN
            load_err  <= 1'b0;
`endif
        end else begin
            hour      <= hour_nxt;
            day_carry <= carry_nxt;
`ifdef HOUR_LOAD_EN
            load_err  <= err_nxt;
`endif
        end
    end

    // Display decode: zero latency from the hour register and timemod.
    logic [4:0] disp_val;
    logic [7:0] disp_bcd;

    always_comb begin
        disp_val = hour;
        if (timemod) begin
            // 12-hour face: hour mod 12, with 0 shown as 12.
            disp_val = (hour >= 5'd12) ? (hour - 5'd12) : hour;
            if (disp_val == 5'd0) begin
                disp_val = 5'd12;
            end
        end
        disp_bcd = to_bcd(disp_val);
    end

    assign hr_tens   = TENS_W'(disp_bcd[7:4]);
    assign hr_units  = UNITS_W'(disp_bcd[3:0]);
    assign pm        = (hour >= 5'd12);
    // Both zero flags reduce to hour == 0: 00 in 24-hour, 12 AM in 12-hour.
    assign heptazero = ~timemod & (hour == 5'd0);
    assign trizero   =  timemod & (hour == 5'd0);

endmodule

// File: tb/tb_hour_counter_cfg.sv
module tb_hour_counter_cfg;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       inc = 1'b0;
    logic       timemod = 1'b0;
    logic [1:0] hr_tens;
    logic [3:0] hr_units;
    logic       pm, day_carry, heptazero, trizero;

    // Second instance with HOUR_MAX = 11
    logic       inc11 = 1'b0;
    logic [1:0] hr_tens11;
    logic [3:0] hr_units11;
    logic       pm11, day_carry11, heptazero11, trizero11;

`ifdef HOUR_LOAD_EN
    logic       load = 1'b0;
    logic [1:0] load_tens = 2'd0;
    logic [3:0] load_units = 4'd0;
    logic       load_err;
    logic       load_err11;
`endif

    int pass_cnt = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    hour_counter_cfg #(.TENS_W(2), .UNITS_W(4), .HOUR_MAX(23)) dut (
        .clk(clk), .rst(rst), .inc(inc), .timemod(timemod),
`ifdef HOUR_LOAD_EN
        .load(load), .load_tens(load_tens), .load_units(load_units),
        .load_err(load_err),
`endif
        .hr_tens(hr_tens), .hr_units(hr_units), .pm(pm),
        .day_carry(day_carry), .heptazero(heptazero), .trizero(trizero)
    );

    hour_counter_cfg #(.TENS_W(2), .UNITS_W(4), .HOUR_MAX(11)) dut11 (
        .clk(clk), .rst(rst), .inc(inc11), .timemod(1'b0),
`ifdef HOUR_LOAD_EN
        .load(1'b0), .load_tens(2'd0), .load_units(4'd0),
        .load_err(load_err11),
`endif
        .hr_tens(hr_tens11), .hr_units(hr_units11), .pm(pm11),
        .day_carry(day_carry11), .heptazero(heptazero11), .trizero(trizero11)
    );

    task automatic apply_reset();
        @(negedge clk);
        inc = 1'b0;
        inc11 = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic pulse_inc(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            inc = 1'b1;
            @(negedge clk);
            inc = 1'b0;
        end
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        timemod = 1'b0;
        #1;
        total_cnt++;
        if ({hr_tens, hr_units} !== {2'd0, 4'd0} || heptazero !== 1'b1 ||
            pm !== 1'b0 || day_carry !== 1'b0 || trizero !== 1'b0)
            $display("FAIL reset_24h: got %0d%0d hz=%b pm=%b dc=%b tz=%b, want 00 hz=1 pm=0 dc=0 tz=0",
                     hr_tens, hr_units, heptazero, pm, day_carry, trizero);
        else pass_cnt++;
        timemod = 1'b1;
        #1;
        total_cnt++;
        if ({hr_tens, hr_units} !== {2'd1, 4'd2} || trizero !== 1'b1 ||
            pm !== 1'b0 || heptazero !== 1'b0)
            $display("FAIL reset_12h: got %0d%0d tz=%b pm=%b hz=%b, want 12 tz=1 pm=0 hz=0",
                     hr_tens, hr_units, trizero, pm, heptazero);
        else pass_cnt++;
        timemod = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_wrap24();
        apply_reset();
        timemod = 1'b0;
        pulse_inc(23);
        total_cnt++;
        if ({hr_tens, hr_units} !== {2'd2, 4'd3} || day_carry !== 1'b0 || pm !== 1'b1)
            $display("FAIL wrap24_at23: got %0d%0d dc=%b pm=%b, want 23 dc=0 pm=1",
                     hr_tens, hr_units, day_carry, pm);
        else pass_cnt++;
        pulse_inc(1);
        total_cnt++;
        if ({hr_tens, hr_units} !== {2'd0, 4'd0} || day_carry !== 1'b1 || heptazero !== 1'b1)
            $display("FAIL wrap24_carry: got %0d%0d dc=%b hz=%b, want 00 dc=1 hz=1",
                     hr_tens, hr_units, day_carry, heptazero);
        else pass_cnt++;
        @(negedge clk);
        #1;
        total_cnt++;
        if (day_carry !== 1'b0 || {hr_tens, hr_units} !== {2'd0, 4'd0})
            $display("FAIL wrap24_carry_len: got dc=%b disp %0d%0d, want dc=0 disp 00",
                     day_carry, hr_tens, hr_units);
        else pass_cnt++;
    endtask

    task automatic test_hold();
        pulse_inc(5);
        repeat (3) @(negedge clk);
        #1;
        total_cnt++;
        if ({hr_tens, hr_units} !== {2'd0, 4'd5} || day_carry !== 1'b0)
            $display("FAIL hold: got %0d%0d dc=%b, want 05 dc=0", hr_tens, hr_units, day_carry);
        else pass_cnt++;
    endtask

    task automatic test_mode_toggle();
        apply_reset();
        timemod = 1'b0;
        pulse_inc(13);
        total_cnt++;
        if ({hr_tens, hr_units} !== {2'd1, 4'd3} || pm !== 1'b1)
            $display("FAIL toggle_24h_a: got %0d%0d pm=%b, want 13 pm=1", hr_tens, hr_units, pm);
        else pass_cnt++;
        timemod = 1'b1;
        #1;
        total_cnt++;
        if ({hr_tens, hr_units} !== {2'd0, 4'd1} || pm !== 1'b1 || trizero !== 1'b0)
            $display("FAIL toggle_12h: got %0d%0d pm=%b tz=%b, want 01 pm=1 tz=0",
                     hr_tens, hr_units, pm, trizero);
        else pass_cnt++;
        @(negedge clk);
        timemod = 1'b0;
        #1;
        total_cnt++;
        if ({hr_tens, hr_units} !== {2'd1, 4'd3} || pm !== 1'b1 || heptazero !== 1'b0)
            $display("FAIL toggle_24h_b: got %0d%0d pm=%b hz=%b, want 13 pm=1 hz=0",
                     hr_tens, hr_units, pm, heptazero);
        else pass_cnt++;
    endtask

    task automatic test_12h_noon();
        apply_reset();
        timemod = 1'b1;
        pulse_inc(12);
        total_cnt++;
        if ({hr_tens, hr_units} !== {2'd1, 4'd2} || pm !== 1'b1 || trizero !== 1'b0)
            $display("FAIL noon_12h: got %0d%0d pm=%b tz=%b, want 12 pm=1 tz=0",
                     hr_tens, hr_units, pm, trizero);
        else pass_cnt++;
        pulse_inc(11);
        total_cnt++;
        if ({hr_tens, hr_units} !== {2'd1, 4'd1} || pm !== 1'b1)
            $display("FAIL 11pm_12h: got %0d%0d pm=%b, want 11 pm=1", hr_tens, hr_units, pm);
        else pass_cnt++;
        pulse_inc(1);
        total_cnt++;
        if ({hr_tens, hr_units} !== {2'd1, 4'd2} || pm !== 1'b0 || trizero !== 1'b1 || day_carry !== 1'b1)
            $display("FAIL midnight_12h: got %0d%0d pm=%b tz=%b dc=%b, want 12 pm=0 tz=1 dc=1",
                     hr_tens, hr_units, pm, trizero, day_carry);
        else pass_cnt++;
        timemod = 1'b0;
    endtask

    task automatic test_hour_max11();
        int pm_seen;
        apply_reset();
        pm_seen = 0;
        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            inc11 = 1'b1;
            @(negedge clk);
            inc11 = 1'b0;
            #1;
            if (pm11 !== 1'b0) pm_seen++;
        end
        total_cnt++;
        if ({hr_tens11, hr_units11} !== {2'd1, 4'd1} || day_carry11 !== 1'b0)
            $display("FAIL max11_at11: got %0d%0d dc=%b, want 11 dc=0",
                     hr_tens11, hr_units11, day_carry11);
        else pass_cnt++;
        @(negedge clk);
        inc11 = 1'b1;
        @(negedge clk);
        inc11 = 1'b0;
        #1;
        if (pm11 !== 1'b0) pm_seen++;
        total_cnt++;
        if ({hr_tens11, hr_units11} !== {2'd0, 4'd0} || day_carry11 !== 1'b1)
            $display("FAIL max11_wrap: got %0d%0d dc=%b, want 00 dc=1",
                     hr_tens11, hr_units11, day_carry11);
        else pass_cnt++;
        @(negedge clk);
        #1;
        total_cnt++;
        if (day_carry11 !== 1'b0 || pm_seen !== 0)
            $display("FAIL max11_after: got dc=%b pm_count=%0d, want dc=0 pm_count=0",
                     day_carry11, pm_seen);
        else pass_cnt++;
    endtask

    task automatic test_async_reset();
        apply_reset();
        timemod = 1'b0;
        pulse_inc(17);
        total_cnt++;
        if ({hr_tens, hr_units} !== {2'd1, 4'd7})
            $display("FAIL async_pre: got %0d%0d, want 17", hr_tens, hr_units);
        else pass_cnt++;
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        total_cnt++;
        if ({hr_tens, hr_units} !== {2'd0, 4'd0} || heptazero !== 1'b1 || pm !== 1'b0 || clk !== 1'b1)
            $display("FAIL async_rst_24h: got %0d%0d hz=%b pm=%b clk=%b, want 00 hz=1 pm=0 clk=1",
                     hr_tens, hr_units, heptazero, pm, clk);
        else pass_cnt++;
        timemod = 1'b1;
        #1;
        total_cnt++;
        if ({hr_tens, hr_units} !== {2'd1, 4'd2} || trizero !== 1'b1 || pm !== 1'b0)
            $display("FAIL async_rst_12h: got %0d%0d tz=%b pm=%b, want 12 tz=1 pm=0",
                     hr_tens, hr_units, trizero, pm);
        else pass_cnt++;
        timemod = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

`ifdef HOUR_LOAD_EN
    task automatic test_load();
        apply_reset();
        timemod = 1'b1;
        @(negedge clk);
        load = 1'b1; load_tens = 2'd2; load_units = 4'd0; inc = 1'b1;
        @(negedge clk);
        load = 1'b0; inc = 1'b0;
        timemod = 1'b0;
        #1;
        total_cnt++;
        if ({hr_tens, hr_units} !== {2'd2, 4'd0} || day_carry !== 1'b0 || load_err !== 1'b0)
            $display("FAIL load_20: got %0d%0d dc=%b err=%b, want 20 dc=0 err=0",
                     hr_tens, hr_units, day_carry, load_err);
        else pass_cnt++;
        @(negedge clk);
        load = 1'b1; load_tens = 2'd2; load_units = 4'd5;
        @(negedge clk);
        load = 1'b0;
        #1;
        total_cnt++;
        if ({hr_tens, hr_units} !== {2'd2, 4'd0} || load_err !== 1'b1)
            $display("FAIL load_bad: got %0d%0d err=%b, want 20 err=1", hr_tens, hr_units, load_err);
        else pass_cnt++;
        @(negedge clk);
        #1;
        total_cnt++;
        if (load_err !== 1'b0 || {hr_tens, hr_units} !== {2'd2, 4'd0})
            $display("FAIL load_err_len: got err=%b disp %0d%0d, want err=0 disp 20",
                     load_err, hr_tens, hr_units);
        else pass_cnt++;
        @(negedge clk);
        load = 1'b1; load_tens = 2'd2; load_units = 4'd3; inc = 1'b1;
        @(negedge clk);
        load = 1'b0; inc = 1'b0;
        #1;
        total_cnt++;
        if ({hr_tens, hr_units} !== {2'd2, 4'd3} || day_carry !== 1'b0)
            $display("FAIL load_23: got %0d%0d dc=%b, want 23 dc=0", hr_tens, hr_units, day_carry);
        else pass_cnt++;
    endtask
`endif

    initial begin
        test_reset();
        test_wrap24();
        test_hold();
        test_mode_toggle();
        test_12h_noon();
        test_hour_max11();
        test_async_reset();
`ifdef HOUR_LOAD_EN
        test_load();
`endif
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
